// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus console FIFO, cycle and drop registers.
// Loads are combinational; stores, pushes and pops commit on the rising edge.
module dmem_responder #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [31:0] cons_data,
   output logic        cons_valid,
   input  logic        cons_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
   localparam logic [31:0] CONS_ADR  = MMIO_BASE;
   localparam logic [31:0] CYCLE_ADR = MMIO_BASE + 32'd4;
   localparam logic [31:0] DROP_ADR  = MMIO_BASE + 32'd8;
   localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);

   logic [31:0] mem [RAM_WORDS];
   logic [31:0] fifoMem [FIFO_DEPTH];

   logic [31:0] wordAdr;
   logic        ramHit;
   logic        consHit;
   logic        cycleHit;
   logic        dropHit;
   logic [AW-1:0] ramIdx;

   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [PW:0]   count;
   logic          full;
   logic          empty;
   logic          pop;
   logic          pushReq;
   logic          pushOk;
   logic          pushDrop;
   logic [7:0]    count8;
   logic [31:0]   statusWord;

   logic [31:0] cycleCnt;
   logic [15:0] dropCnt;

   assign wordAdr  = DataAdr & ~32'h3;
   assign ramHit   = DataAdr < RAM_BYTES;
   assign consHit  = wordAdr == CONS_ADR;
   assign cycleHit = wordAdr == CYCLE_ADR;
   assign dropHit  = wordAdr == DROP_ADR;
   assign ramIdx   = DataAdr[AW+1:2];

   assign full       = count == FULL_CNT;
   assign empty      = count == '0;
   assign cons_valid = !empty;
   assign cons_data  = fifoMem[rdPtr];

   // A pop on a full FIFO frees the slot the same-cycle push lands in.
   assign pop      = cons_valid && cons_ready;
   assign pushReq  = MemWrite && consHit;
   assign pushOk   = pushReq && (!full || pop);
   assign pushDrop = pushReq && !pushOk;

   assign count8     = 8'(count);
   assign statusWord = {full, empty, 22'b0, count8};

   // RAM store port; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && MemWrite && ramHit) begin
         mem[ramIdx] <= WriteData;
      end
   end

   // FIFO storage; an accepted push writes the tail slot.
   always_ff @(posedge clk) begin
      if (!reset && pushOk) begin
         fifoMem[wrPtr] <= WriteData;
      end
   end

   // FIFO pointers and occupancy; reset flushes all queued entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         if (pushOk) begin
            wrPtr <= wrPtr + PW'(1);
         end
         unique case ({pushOk, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Free-running cycle counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycleCnt <= '0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
      end
   end

   // Rejected-push counter: cleared by any store to it, saturates at max.
   always_ff @(posedge clk) begin
      if (reset) begin
         dropCnt <= '0;
      end else if (MemWrite && dropHit) begin
         dropCnt <= '0;
      end else if (pushDrop && dropCnt != 16'hFFFF) begin
         dropCnt <= dropCnt + 16'd1;
      end
   end

   // Zero-latency load mux; same-cycle stores are not forwarded.
   always_comb begin
      ReadData = '0;
      unique case (1'b1)
         ramHit:   ReadData = mem[ramIdx];
         consHit:  ReadData = statusWord;
         cycleHit: ReadData = cycleCnt;
         dropHit:  ReadData = {16'b0, dropCnt};
         default:  ReadData = '0;
      endcase
   end

endmodule
